pipe_trace_rec: RTL and testbench

- Parametrised successor to the single-pipeline trace printer.
- Tracks instruction IDs through an N-stage pipeline and detects stage-entry, retire and flush events each cycle.
- Packs each cycle's events into one fixed-width record, compressing idle cycles into a gap count.
- Buffers records in a FIFO for a downstream consumer: a Konata file writer in sim or a debug port on FPGA.

---
 rtl/trace_pkg.sv | 33 +++
 rtl/trace_fifo.sv | 57 +++++
 rtl/pipe_trace_rec.sv | 112 +++++++++++
 tb/tb_pipe_trace_rec.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Record layout helpers for the pipeline trace recorder. The RTL, Konata writers
// and the bench all decode records through these offsets.
package trace_pkg;

  function automatic int rec_w(input int ns, input int idw, input int gw);
    return gw + 2 * ns + (ns + 1) * idw + 1;
  endfunction

  function automatic int ret_lsb();
    return 0;
  endfunction

  function automatic int ret_v_bit(input int idw);
    return idw;
  endfunction

  function automatic int id_lsb(input int s, input int idw);
    return idw + 1 + s * idw;
  endfunction

  function automatic int flush_lsb(input int ns, input int idw);
    return idw + 1 + ns * idw;
  endfunction

  function automatic int new_lsb(input int ns, input int idw);
    return flush_lsb(ns, idw) + ns;
  endfunction

  function automatic int gap_lsb(input int ns, input int idw);
    return new_lsb(ns, idw) + ns;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO with a valid/ready read port. A push into a full FIFO
// is accepted only when the head is popped in the same cycle.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             push_ok_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             empty_q, full_q, pop;

  assign pop       = rd_ready_i & ~empty_q;
  assign push_ok_o = push_i & (~full_q | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok_o);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      empty_q  <= (wr_ptr_d == rd_ptr_d);
      full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok_o) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign rd_valid_o = ~empty_q;
  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/pipe_trace_rec.sv
// Pipeline trace recorder: follows instruction IDs through NUM_STAGES stages and
// packs each cycle's entry/flush/retire events into one gap-compressed record.
module pipe_trace_rec
  import trace_pkg::*;
#(
  parameter  int NUM_STAGES = 4,
  parameter  int ID_W       = 16,
  parameter  int GAP_W      = 12,
  parameter  int DEPTH      = 8,
  localparam int REC_W      = rec_w(NUM_STAGES, ID_W, GAP_W)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trace_en,
  input  logic [NUM_STAGES-1:0] stage_new,
  input  logic [NUM_STAGES-1:0] stage_flush,
  input  logic                  retire,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [REC_W-1:0]      rec_data,
  output logic                  overflow,
  output logic [15:0]           drop_cnt
);

  localparam int LAST      = NUM_STAGES - 1;
  localparam int GAP_LSB   = gap_lsb(NUM_STAGES, ID_W);
  localparam int NEW_LSB   = new_lsb(NUM_STAGES, ID_W);
  localparam int FLUSH_LSB = flush_lsb(NUM_STAGES, ID_W);
  localparam logic [GAP_W-1:0] GAP_MAX = '1;

  logic [ID_W-1:0]       next_id_q;
  logic [ID_W-1:0]       id_q   [NUM_STAGES];
  logic [ID_W-1:0]       cur_id [NUM_STAGES];
  logic [NUM_STAGES-1:0] occ_q, occ_d, leave, flush_ev;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  ret_ev, push_req, push_ok, drop;
  logic                  overflow_q;
  logic [15:0]           drop_cnt_q;
  logic [REC_W-1:0]      rec;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    if (s == 0) begin : g_fetch
      assign cur_id[s] = stage_new[s] ? next_id_q : id_q[s];
    end else begin : g_follow
      assign cur_id[s] = stage_new[s] ? id_q[s-1] : id_q[s];
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    leave       = '0;
    leave[LAST] = retire;
    for (int s = 0; s < LAST; s++) leave[s] = stage_new[s+1];
    flush_ev = stage_flush & occ_q;
    // A flush of the last stage squashes the instruction, so it cannot also retire.
    ret_ev   = retire & occ_q[LAST] & ~stage_flush[LAST];
    occ_d    = stage_new | (occ_q & ~stage_flush & ~leave);
    push_req = trace_en & ((|stage_new) | (|flush_ev) | ret_ev | (gap_q == GAP_MAX));
    drop     = push_req & ~push_ok;
    if (push_ok)               gap_d = GAP_W'(1);
    else if (gap_q == GAP_MAX) gap_d = gap_q;
    else                       gap_d = gap_q + GAP_W'(1);
  end

  always_comb begin
    rec = '0;
    rec[GAP_LSB +: GAP_W]        = gap_q;
    rec[NEW_LSB +: NUM_STAGES]   = stage_new;
    rec[FLUSH_LSB +: NUM_STAGES] = flush_ev;
    for (int s = 0; s < NUM_STAGES; s++) rec[id_lsb(s, ID_W) +: ID_W] = cur_id[s];
    rec[ret_v_bit(ID_W)]         = ret_ev;
    rec[ret_lsb() +: ID_W]       = ret_ev ? id_q[LAST] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      next_id_q  <= '0;
      occ_q      <= '0;
      gap_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int s = 0; s < NUM_STAGES; s++) id_q[s] <= '0;
    end else begin
      if (stage_new[0]) next_id_q <= next_id_q + ID_W'(1);
      for (int s = 0; s < NUM_STAGES; s++) id_q[s] <= cur_id[s];
      occ_q <= occ_d;
      gap_q <= gap_d;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_req),
    .push_data_i (rec),
    .push_ok_o   (push_ok),
    .rd_valid_o  (rec_valid),
    .rd_ready_i  (rec_ready),
    .rd_data_o   (rec_data)
  );

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pipe_trace_rec.sv
// Self-checking bench for pipe_trace_rec: directed scenarios plus random traffic,
// compared against a cycle-timestamp / queue reference model.
module tb_pipe_trace_rec;
  import trace_pkg::*;

  localparam int NS      = 4;
  localparam int IDW     = 16;
  localparam int GW      = 12;
  localparam int DEPTH   = 8;
  localparam int REC_W   = rec_w(NS, IDW, GW);
  localparam int LAST    = NS - 1;
  localparam int GAP_SAT = (1 << GW) - 1;
  localparam int GAP_LSB = gap_lsb(NS, IDW);
  localparam int NEW_LSB = new_lsb(NS, IDW);
  localparam int FL_LSB  = flush_lsb(NS, IDW);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             trace_en = 1'b0;
  logic             retire = 1'b0;
  logic             rec_ready = 1'b0;
  logic [NS-1:0]    stage_new = '0;
  logic [NS-1:0]    stage_flush = '0;
  logic             rec_valid, overflow;
  logic [REC_W-1:0] rec_data;
  logic [15:0]      drop_cnt;

  pipe_trace_rec #(.NUM_STAGES(NS), .ID_W(IDW), .GAP_W(GW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .trace_en    (trace_en),
    .stage_new   (stage_new),
    .stage_flush (stage_flush),
    .retire      (retire),
    .rec_valid   (rec_valid),
    .rec_ready   (rec_ready),
    .rec_data    (rec_data),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int gap;
    int nmask;
    int fmask;
    int ids[NS];
    bit ret_v;
    int ret_id;
  } rec_t;

  // Reference model: stages hold "the last ID seen here" plus a busy flag,
  // gap is derived from cycle timestamps, the FIFO is a bounded queue.
  rec_t exp_q[$];
  int   m_cycle, m_last_push, m_next_id, m_drops;
  int   m_hold[NS];
  bit   m_busy[NS];
  bit   m_ovf;

  task automatic model_reset();
    exp_q.delete();
    m_cycle = 0; m_last_push = 0; m_next_id = 0; m_drops = 0; m_ovf = 1'b0;
    for (int s = 0; s < NS; s++) begin m_hold[s] = 0; m_busy[s] = 1'b0; end
  endtask

  task automatic do_reset();
    reset = 1'b0; trace_en = 1'b0; stage_new = '0; stage_flush = '0;
    retire = 1'b0; rec_ready = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  task automatic compare_head(input rec_t h);
    check("gap", 64'(rec_data[GAP_LSB +: GW]), 64'(h.gap));
    check("new_mask", 64'(rec_data[NEW_LSB +: NS]), 64'(h.nmask));
    check("flush_mask", 64'(rec_data[FL_LSB +: NS]), 64'(h.fmask));
    for (int s = 0; s < NS; s++)
      check($sformatf("cur_id[%0d]", s), 64'(rec_data[id_lsb(s, IDW) +: IDW]), 64'(h.ids[s]));
    check("ret_v", 64'(rec_data[ret_v_bit(IDW)]), 64'(h.ret_v));
    if (h.ret_v) check("ret_id", 64'(rec_data[ret_lsb() +: IDW]), 64'(h.ret_id));
  endtask

  // One clock: drive inputs at the falling edge, check outputs, advance the model.
  task automatic step(input logic [NS-1:0] nw, input logic [NS-1:0] fl,
                      input logic rt, input logic en, input logic rdy);
    int   cur[NS];
    int   gap, fmask;
    bit   rev, push, pop;
    rec_t r;
    reset = 1'b1; stage_new = nw; stage_flush = fl; retire = rt;
    trace_en = en; rec_ready = rdy;
    check("rec_valid", 64'(rec_valid), 64'(exp_q.size() != 0));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drops));
    pop = rdy && (exp_q.size() != 0);
    if (pop) begin
      compare_head(exp_q[0]);
      void'(exp_q.pop_front());
    end
    for (int s = 0; s < NS; s++) begin
      if (!nw[s])      cur[s] = m_hold[s];
      else if (s == 0) cur[s] = m_next_id;
      else             cur[s] = m_hold[s-1];
    end
    fmask = 0;
    for (int s = 0; s < NS; s++) if (fl[s] && m_busy[s]) fmask |= (1 << s);
    rev  = rt && m_busy[LAST] && !fl[LAST];
    gap  = (m_cycle - m_last_push > GAP_SAT) ? GAP_SAT : m_cycle - m_last_push;
    push = en && (nw != 0 || fmask != 0 || rev || gap == GAP_SAT);
    if (push) begin
      if (exp_q.size() < DEPTH) begin
        r.gap = gap; r.nmask = int'(nw); r.fmask = fmask; r.ret_v = rev;
        r.ret_id = m_hold[LAST];
        for (int s = 0; s < NS; s++) r.ids[s] = cur[s];
        exp_q.push_back(r);
        m_last_push = m_cycle;
      end else begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
    end
    for (int s = 0; s < NS; s++) begin
      bit gone;
      gone = (s == LAST) ? rt : nw[s+1];
      m_busy[s] = nw[s] || (m_busy[s] && !fl[s] && !gone);
      m_hold[s] = cur[s];
    end
    if (nw[0]) m_next_id = (m_next_id + 1) % (1 << IDW);
    m_cycle++;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Idle after reset, then one instruction walked through every stage and retired.
    repeat (6) step('0, '0, 1'b0, 1'b1, 1'b1);
    step(4'b0001, '0, 1'b0, 1'b1, 1'b1);
    step(4'b0010, '0, 1'b0, 1'b1, 1'b1);
    step(4'b0100, '0, 1'b0, 1'b1, 1'b1);
    step(4'b1000, '0, 1'b0, 1'b1, 1'b1);
    step('0, '0, 1'b1, 1'b1, 1'b1);
    repeat (3) step('0, '0, 1'b0, 1'b1, 1'b1);

    // Three in flight, flush the two youngest, retire the oldest.
    do_reset();
    step(4'b0001, '0, 1'b0, 1'b1, 1'b1);
    step(4'b0011, '0, 1'b0, 1'b1, 1'b1);
    step(4'b0111, '0, 1'b0, 1'b1, 1'b1);
    step('0, 4'b0011, 1'b0, 1'b1, 1'b1);
    step(4'b1000, '0, 1'b0, 1'b1, 1'b1);
    step('0, '0, 1'b1, 1'b1, 1'b1);
    step('0, '0, 1'b1, 1'b1, 1'b1);
    repeat (3) step('0, '0, 1'b0, 1'b1, 1'b1);

    // Back-pressure: ten event cycles into an eight-deep FIFO, then drain.
    repeat (10) step(4'b0001, '0, 1'b0, 1'b1, 1'b0);
    repeat (3) step('0, '0, 1'b0, 1'b1, 1'b0);
    repeat (10) step('0, '0, 1'b0, 1'b1, 1'b1);
    step(4'b0010, '0, 1'b0, 1'b1, 1'b1);
    repeat (3) step('0, '0, 1'b0, 1'b1, 1'b1);

    // Long idle stretch forces a gap-saturation record.
    do_reset();
    repeat (GAP_SAT + 5) step('0, '0, 1'b0, 1'b1, 1'b1);
    step(4'b0001, '0, 1'b0, 1'b1, 1'b1);
    repeat (3) step('0, '0, 1'b0, 1'b1, 1'b1);

    // Random traffic, including simultaneous new/flush and retire/flush.
    for (int i = 0; i < 3000; i++)
      step(NS'($urandom), ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0,
           1'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);
    repeat (12) step('0, '0, 1'b0, 1'b1, 1'b1);

    // ID wrap: advance next_id to its last value untraced, then fetch twice.
    do_reset();
    repeat ((1 << IDW) - 1) step(4'b0001, '0, 1'b0, 1'b0, 1'b1);
    step(4'b0001, '0, 1'b0, 1'b1, 1'b0);
    step(4'b0001, '0, 1'b0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b1, 1'b1);
    step('0, '0, 1'b0, 1'b1, 1'b0);

    // Reset with records still buffered must empty the FIFO and restart IDs.
    do_reset();
    step(4'b0001, '0, 1'b0, 1'b1, 1'b1);
    repeat (3) step('0, '0, 1'b0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
